std_div_seq: RTL and testbench

- Multi-cycle unsigned restoring divider with a go/done handshake.
- Sits upstream of the register/memory primitives: produces quotient and remainder that the control logic latches into std_reg or writes to std_mem_d*.
- Completes one quotient bit per cycle, so latency is WIDTH-proportional but area stays small for arbitrary WIDTH.
- Not limited to the fixed-width gate-level implementation set.

---
 rtl/std_div_seq.sv | 94 +++++++++
 tb/tb_std_div_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/std_div_seq.sv
// Unsigned restoring divider: one quotient bit per cycle, go/done handshake.
// Latency WIDTH+1 cycles from acceptance to done; go is only sampled in IDLE (no backpressure).
module std_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] rem_nxt;

  // The dividend register doubles as the quotient: bits shift out the top
  // into the remainder while quotient bits enter at the bottom.
  always_comb begin
    rem_sh     = {rem, dvd[WIDTH-1]};
    trial      = rem_sh - {1'b0, divisor};
    dvd_nxt    = dvd << 1;
    dvd_nxt[0] = ~trial[WIDTH];
    rem_nxt    = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go) state_nxt = S_BUSY;
      S_BUSY:  if (cnt == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd           <= '0;
      divisor       <= '0;
      rem           <= '0;
      cnt           <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            dvd     <= left;
            divisor <= right;
            rem     <= '0;
            cnt     <= '0;
          end
        end
        S_BUSY: begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_quotient  <= dvd_nxt;
            out_remainder <= rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign done = (state == S_DONE);

endmodule

// File: tb/tb_std_div_seq.sv
// Bench for std_div_seq: WIDTH=8 table vectors via scoreboard, plus a WIDTH=32 sweep.
module tb_std_div_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       go8 = 1'b0;
  logic [7:0] l8 = '0, r8 = '0, q8, rm8;
  logic       done8;

  logic        go32 = 1'b0;
  logic [31:0] l32 = '0, r32 = '0, q32, rm32;
  logic        done32;

  std_div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .go(go8), .left(l8), .right(r8),
    .out_quotient(q8), .out_remainder(rm8), .done(done8)
  );

  std_div_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .go(go32), .left(l32), .right(r32),
    .out_quotient(q32), .out_remainder(rm32), .done(done32)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
    logic [7:0] q;
    logic [7:0] rm;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] rm;
    int         due;
  } exp8_t;

  exp8_t      sb8[$];
  logic [7:0] hold_q = '0, hold_r = '0;
  logic       done8_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops expected results on done and checks that outputs hold in between.
  always @(negedge clk) begin
    if (done8) begin
      check("done8_single_pulse", {31'd0, done8_prev}, 32'd0);
      if (sb8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp8_t e;
        e = sb8.pop_front();
        check("q8", q8, e.q);
        check("r8", rm8, e.rm);
        check("latency8_cycle", cyc, e.due);
        hold_q = e.q;
        hold_r = e.rm;
      end
    end else if (reset) begin
      hold_q = '0;
      hold_r = '0;
    end else begin
      check("q8_hold", q8, hold_q);
      check("r8_hold", rm8, hold_r);
    end
    done8_prev = done8;
  end

  task automatic wait_empty8(input string name);
    int n = 0;
    while (sb8.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb8.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb8.size());
      sb8.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run8(input vec_t v);
    go8 = 1'b1;
    l8  = v.l;
    r8  = v.r;
    sb8.push_back('{q: v.q, rm: v.rm, due: cyc + 1 + 8});
    @(negedge clk);
    go8 = 1'b0;
    l8  = 8'($urandom);
    r8  = 8'($urandom);
    wait_empty8("op8");
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    int due, n;
    eq = (b == 0) ? 32'hFFFF_FFFF : a / b;
    er = (b == 0) ? a : a % b;
    go32 = 1'b1;
    l32  = a;
    r32  = b;
    due  = cyc + 1 + 32;
    @(negedge clk);
    go32 = 1'b0;
    l32  = $urandom;
    r32  = $urandom;
    n = 0;
    while (!done32 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done32_seen", {31'd0, done32}, 32'd1);
    check("latency32_cycle", cyc, due);
    check("q32", q32, eq);
    check("r32", rm32, er);
    @(negedge clk);
    check("done32_pulse_low", {31'd0, done32}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   base;
    vecs[0] = '{l: 8'd100, r: 8'd7, q: 8'd14,  rm: 8'd2};
    vecs[1] = '{l: 8'd255, r: 8'd1, q: 8'd255, rm: 8'd0};
    vecs[2] = '{l: 8'd5,   r: 8'd9, q: 8'd0,   rm: 8'd5};
    vecs[3] = '{l: 8'd0,   r: 8'd3, q: 8'd0,   rm: 8'd0};
    vecs[4] = '{l: 8'd77,  r: 8'd0, q: 8'd255, rm: 8'd77};
    vecs[5] = '{l: 8'd200, r: 8'd3, q: 8'd66,  rm: 8'd2};

    repeat (3) @(negedge clk);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_q8", q8, 32'd0);
    check("rst_r8", rm8, 32'd0);
    check("rst_done32", {31'd0, done32}, 32'd0);
    check("rst_q32", q32, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run8(vecs[i]);

    // go held high: inputs changed mid-operation are ignored, next op samples them in IDLE
    go8 = 1'b1;
    l8  = 8'd100;
    r8  = 8'd7;
    base = cyc;
    sb8.push_back('{q: 8'd14, rm: 8'd2, due: base + 1 + 8});
    sb8.push_back('{q: 8'd66, rm: 8'd2, due: base + 1 + 18});
    repeat (3) @(negedge clk);
    l8 = 8'd200;
    r8 = 8'd3;
    while (cyc < base + 19) @(negedge clk);
    go8 = 1'b0;
    wait_empty8("b2b");

    // reset four cycles into an operation discards it
    go8 = 1'b1;
    l8  = 8'd100;
    r8  = 8'd7;
    sb8.push_back('{q: 8'd14, rm: 8'd2, due: cyc + 1 + 8});
    @(negedge clk);
    go8 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    sb8.delete();
    repeat (2) @(negedge clk);
    check("midrst_done8", {31'd0, done8}, 32'd0);
    check("midrst_q8", q8, 32'd0);
    check("midrst_r8", rm8, 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    run8('{l: 8'd50, r: 8'd6, q: 8'd8, rm: 8'd2});

    run32(32'hFFFF_FFFF, 32'h0001_0000);
    run32(32'd12345, 32'd0);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i % 7 == 3) b = 32'd0;
      run32(a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
